// File: rtl/br_tracker_reorder_buffer_arb_pkg.sv
// Helpers shared by the reorder-buffer allocation tracker and its arbiter.
// Deliberately holds no types: widths stay local to each module.
package br_tracker_reorder_buffer_arb_pkg;

   // Index width that never collapses to zero bits for a single-element range.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/br_tracker_reorder_buffer_arb_rr.sv
// Round-robin arbiter: combinational grant (0 cycles), search starts at ptr_q.
// The pointer only moves when advance_i reports an accepted grant; otherwise it holds.
module br_arb_rr
   import br_tracker_reorder_buffer_arb_pkg::*;
#(
   parameter int NumRequesters = 2
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [NumRequesters-1:0]                request_i,
   input  logic                                    advance_i,
   output logic [NumRequesters-1:0]                grant_o,
   output logic [idx_width(NumRequesters)-1:0]     grant_idx_o
);

   localparam int IdxWidth = idx_width(NumRequesters);
   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumRequesters - 1);

   logic [IdxWidth-1:0] ptr_q, ptr_d;
   logic                found;

   // Two passes: indices at/after the pointer first, then the wrapped-around ones.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      for (int i = 0; i < NumRequesters; i++) begin
         if (!found && request_i[i] && (IdxWidth'(i) >= ptr_q)) begin
            found       = 1'b1;
            grant_o[i]  = 1'b1;
            grant_idx_o = IdxWidth'(i);
         end
      end
      for (int i = 0; i < NumRequesters; i++) begin
         if (!found && request_i[i] && (IdxWidth'(i) < ptr_q)) begin
            found       = 1'b1;
            grant_o[i]  = 1'b1;
            grant_idx_o = IdxWidth'(i);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance_i) begin
         ptr_d = (grant_idx_o == LastIdx) ? '0 : grant_idx_o + IdxWidth'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/br_tracker_reorder_buffer_arb.sv
// Shares one reorder buffer among requesters: RR alloc grant and owner-routed completions, both 0-cycle.
// Alloc ready drops when no eligible requester; completion ready mirrors the owning requester's ready.
module br_tracker_reorder_buffer_arb
   import br_tracker_reorder_buffer_arb_pkg::*;
#(
   parameter int NumRequesters  = 2,
   parameter int NumEntries     = 4,
   parameter int EntryIdWidth   = 2,
   parameter int MaxOutstanding = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NumRequesters-1:0] req_alloc_ready,
   output logic [NumRequesters-1:0] req_alloc_valid,
   output logic [EntryIdWidth-1:0]  req_alloc_entry_id,
   output logic                     rob_alloc_ready,
   input  logic                     rob_alloc_valid,
   input  logic [EntryIdWidth-1:0]  rob_alloc_entry_id,
   input  logic                     rob_complete_valid,
   input  logic [EntryIdWidth-1:0]  rob_complete_entry_id,
   output logic                     rob_complete_ready,
   output logic [NumRequesters-1:0] req_complete_valid,
   input  logic [NumRequesters-1:0] req_complete_ready,
   output logic [NumRequesters-1:0] req_at_cap
);

   localparam int CountWidth = $clog2(MaxOutstanding + 1);
   localparam int OwnerWidth = idx_width(NumRequesters);
   localparam logic [CountWidth-1:0] CountMax = CountWidth'(MaxOutstanding);

   logic [NumRequesters-1:0] eligible;
   logic [NumRequesters-1:0] grant;
   logic [OwnerWidth-1:0]    grant_idx;
   logic [NumRequesters-1:0] inc;
   logic [NumRequesters-1:0] dec;
   logic                     alloc_xfer;
   logic                     cpl_xfer;
   logic [OwnerWidth-1:0]    cpl_owner;
   logic                     cpl_inuse;
   logic                     alloc_inuse;

   logic [OwnerWidth-1:0]    owner_q [NumEntries];
   logic [NumEntries-1:0]    inuse_q, inuse_d;
   logic [CountWidth-1:0]    count_q [NumRequesters];
   logic [CountWidth-1:0]    count_d [NumRequesters];

   always_comb begin
      req_at_cap = '0;
      for (int i = 0; i < NumRequesters; i++) begin
         req_at_cap[i] = (count_q[i] == CountMax);
      end
   end

   assign eligible           = req_alloc_ready & ~req_at_cap;
   assign rob_alloc_ready    = |eligible;
   assign req_alloc_valid    = {NumRequesters{rob_alloc_valid}} & grant;
   assign req_alloc_entry_id = rob_alloc_entry_id;
   assign alloc_xfer         = rob_alloc_valid & rob_alloc_ready;

   br_arb_rr #(
      .NumRequesters (NumRequesters)
   ) u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .request_i   (eligible),
      .advance_i   (alloc_xfer),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   // Table lookups by comparison so IDs beyond NumEntries read as unowned/free.
   always_comb begin
      cpl_owner   = '0;
      cpl_inuse   = 1'b0;
      alloc_inuse = 1'b0;
      for (int e = 0; e < NumEntries; e++) begin
         if (rob_complete_entry_id == EntryIdWidth'(e)) begin
            cpl_owner = owner_q[e];
            cpl_inuse = inuse_q[e];
         end
         if (rob_alloc_entry_id == EntryIdWidth'(e)) begin
            alloc_inuse = inuse_q[e];
         end
      end
   end

   always_comb begin
      req_complete_valid = '0;
      rob_complete_ready = 1'b0;
      for (int i = 0; i < NumRequesters; i++) begin
         if (cpl_owner == OwnerWidth'(i)) begin
            req_complete_valid[i] = rob_complete_valid;
            rob_complete_ready    = req_complete_ready[i];
         end
      end
   end

   assign cpl_xfer = rob_complete_valid & rob_complete_ready;
   assign inc      = {NumRequesters{alloc_xfer}} & grant;
   assign dec      = {NumRequesters{cpl_xfer}} & req_complete_valid;

   // Saturating in both directions; a simultaneous +1/-1 cancels.
   always_comb begin
      for (int i = 0; i < NumRequesters; i++) begin
         count_d[i] = count_q[i];
         if (inc[i] && !dec[i] && (count_q[i] != CountMax)) begin
            count_d[i] = count_q[i] + CountWidth'(1);
         end else if (dec[i] && !inc[i] && (count_q[i] != '0)) begin
            count_d[i] = count_q[i] - CountWidth'(1);
         end
      end
   end

   // Set after clear: re-allocating the completing entry leaves it in use.
   always_comb begin
      inuse_d = inuse_q;
      for (int e = 0; e < NumEntries; e++) begin
         if (cpl_xfer && (rob_complete_entry_id == EntryIdWidth'(e))) begin
            inuse_d[e] = 1'b0;
         end
         if (alloc_xfer && (rob_alloc_entry_id == EntryIdWidth'(e))) begin
            inuse_d[e] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inuse_q <= '0;
         for (int i = 0; i < NumRequesters; i++) begin
            count_q[i] <= '0;
         end
      end else begin
         inuse_q <= inuse_d;
         for (int i = 0; i < NumRequesters; i++) begin
            count_q[i] <= count_d[i];
         end
      end
   end

   // Owner contents are only meaningful while inuse is set, so no reset here.
   always_ff @(posedge clk) begin
      for (int e = 0; e < NumEntries; e++) begin
         if (alloc_xfer && (rob_alloc_entry_id == EntryIdWidth'(e))) begin
            owner_q[e] <= grant_idx;
         end
      end
   end

   a_alloc_free: assert property (@(posedge clk) disable iff (!rst_n)
      alloc_xfer |-> (!alloc_inuse ||
                      (cpl_xfer && (rob_complete_entry_id == rob_alloc_entry_id))));

   a_cpl_inuse: assert property (@(posedge clk) disable iff (!rst_n)
      rob_complete_valid |-> cpl_inuse);

   a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(grant));

   a_grant_onehot_xfer: assert property (@(posedge clk) disable iff (!rst_n)
      alloc_xfer |-> $onehot(grant));

   for (genvar gi = 0; gi < NumRequesters; gi++) begin : g_count_chk
      a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
         !(inc[gi] && !dec[gi] && (count_q[gi] == CountMax)));
      a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
         !(dec[gi] && !inc[gi] && (count_q[gi] == '0)));
   end

endmodule

// File: tb/tb_br_tracker_reorder_buffer_arb.sv
// Bench for br_tracker_reorder_buffer_arb: directed scenarios plus random traffic
// against a queue-based model of owners, counts and the round-robin pointer.
module tb_br_tracker_reorder_buffer_arb;
   localparam int N    = 2;
   localparam int ENT  = 4;
   localparam int IDW  = 2;
   localparam int MAXO = 2;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req_alloc_ready, req_alloc_valid, req_complete_valid;
   logic [N-1:0]   req_complete_ready, req_at_cap;
   logic [IDW-1:0] req_alloc_entry_id, rob_alloc_entry_id, rob_complete_entry_id;
   logic           rob_alloc_ready, rob_alloc_valid, rob_complete_valid, rob_complete_ready;

   br_tracker_reorder_buffer_arb #(
      .NumRequesters (N),
      .NumEntries    (ENT),
      .EntryIdWidth  (IDW),
      .MaxOutstanding(MAXO)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .req_alloc_ready      (req_alloc_ready),
      .req_alloc_valid      (req_alloc_valid),
      .req_alloc_entry_id   (req_alloc_entry_id),
      .rob_alloc_ready      (rob_alloc_ready),
      .rob_alloc_valid      (rob_alloc_valid),
      .rob_alloc_entry_id   (rob_alloc_entry_id),
      .rob_complete_valid   (rob_complete_valid),
      .rob_complete_entry_id(rob_complete_entry_id),
      .rob_complete_ready   (rob_complete_ready),
      .req_complete_valid   (req_complete_valid),
      .req_complete_ready   (req_complete_ready),
      .req_at_cap           (req_at_cap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   int m_cnt [N];
   int m_ptr;
   int m_owner [ENT];
   bit m_inuse [ENT];
   int m_order [$];

   logic [N-1:0] e_alloc_valid, e_cpl_valid, e_at_cap;
   logic         e_rob_alloc_ready, e_rob_cpl_ready;
   int           e_gidx;

   task automatic set_idle();
      req_alloc_ready       = '0;
      req_complete_ready    = '0;
      rob_alloc_valid       = 1'b0;
      rob_alloc_entry_id    = '0;
      rob_complete_valid    = 1'b0;
      rob_complete_entry_id = '0;
   endtask

   task automatic model_reset();
      m_ptr = 0;
      m_order.delete();
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      for (int e = 0; e < ENT; e++) m_inuse[e] = 1'b0;
   endtask

   task automatic model_eval();
      int own;
      e_at_cap = '0;
      e_gidx   = -1;
      for (int i = 0; i < N; i++) e_at_cap[i] = (m_cnt[i] == MAXO);
      for (int off = 0; off < N; off++) begin
         int k;
         k = (m_ptr + off) % N;
         if (e_gidx < 0 && req_alloc_ready[k] && !e_at_cap[k]) e_gidx = k;
      end
      e_rob_alloc_ready = (e_gidx >= 0);
      e_alloc_valid = '0;
      if (rob_alloc_valid && e_gidx >= 0) e_alloc_valid[e_gidx] = 1'b1;
      e_cpl_valid     = '0;
      e_rob_cpl_ready = 1'b0;
      if (rob_complete_valid) begin
         own = m_owner[int'(rob_complete_entry_id)];
         e_cpl_valid[own] = 1'b1;
         e_rob_cpl_ready  = req_complete_ready[own];
      end
   endtask

   task automatic model_commit();
      int own, cid, aid;
      bit a, c;
      model_eval();
      cid = int'(rob_complete_entry_id);
      aid = int'(rob_alloc_entry_id);
      a = rob_alloc_valid && e_rob_alloc_ready;
      c = rob_complete_valid && e_rob_cpl_ready;
      if (c) begin
         own = m_owner[cid];
         m_cnt[own]--;
         m_inuse[cid] = 1'b0;
         for (int j = 0; j < m_order.size(); j++) begin
            if (m_order[j] == cid) begin
               m_order.delete(j);
               break;
            end
         end
      end
      if (a) begin
         m_cnt[e_gidx]++;
         m_ptr        = (e_gidx + 1) % N;
         m_owner[aid] = e_gidx;
         m_inuse[aid] = 1'b1;
         m_order.push_back(aid);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_commit();
      @(negedge clk);
   endtask

   task automatic do_reset();
      set_idle();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      set_idle();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      req_alloc_ready    = 2'b10;
      rob_alloc_valid    = 1'b1;
      rob_alloc_entry_id = 2'd2;
      #1;
      n_checks++;
      if (req_at_cap !== 2'b00) $display("FAIL reset_at_cap: got %b want 00", req_at_cap); else n_pass++;
      n_checks++;
      if (rob_alloc_ready !== 1'b1) $display("FAIL reset_alloc_ready: got %b want 1", rob_alloc_ready); else n_pass++;
      n_checks++;
      if (req_alloc_valid !== 2'b10) $display("FAIL reset_grant_single: got %b want 10", req_alloc_valid); else n_pass++;
      n_checks++;
      if (req_alloc_entry_id !== 2'd2) $display("FAIL reset_entry_id: got %0d want 2", req_alloc_entry_id); else n_pass++;
      n_checks++;
      if (req_complete_valid !== 2'b00) $display("FAIL reset_cpl_valid: got %b want 00", req_complete_valid); else n_pass++;
      req_alloc_ready = 2'b11;
      repeat (2) begin
         @(negedge clk);
         #1;
         n_checks++;
         if (req_alloc_valid !== 2'b01) $display("FAIL reset_ptr_zero: got %b want 01", req_alloc_valid); else n_pass++;
      end
      set_idle();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic [N-1:0] want;
      do_reset();
      req_alloc_ready = 2'b11;
      rob_alloc_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         rob_alloc_entry_id = IDW'(k);
         want = (k % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         n_checks++;
         if (req_alloc_valid !== want) $display("FAIL rr_grant[%0d]: got %b want %b", k, req_alloc_valid, want); else n_pass++;
         n_checks++;
         if (req_alloc_entry_id !== IDW'(k)) $display("FAIL rr_entry_id[%0d]: got %0d want %0d", k, req_alloc_entry_id, k); else n_pass++;
         tick();
      end
      #1;
      n_checks++;
      if (req_at_cap !== 2'b11) $display("FAIL rr_both_cap: got %b want 11", req_at_cap); else n_pass++;
      n_checks++;
      if (rob_alloc_ready !== 1'b0) $display("FAIL rr_alloc_ready_low: got %b want 0", rob_alloc_ready); else n_pass++;
   endtask

   task automatic test_alloc_cap();
      int grants, id;
      do_reset();
      grants = 0;
      id     = 0;
      req_alloc_ready = 2'b01;
      rob_alloc_valid = 1'b1;
      for (int cyc = 0; cyc < 4; cyc++) begin
         rob_alloc_entry_id = IDW'(id);
         #1;
         model_eval();
         n_checks++;
         if (req_alloc_valid !== e_alloc_valid) $display("FAIL cap_grant[%0d]: got %b want %b", cyc, req_alloc_valid, e_alloc_valid); else n_pass++;
         if (req_alloc_valid[0] && rob_alloc_ready) begin
            grants++;
            id++;
         end
         tick();
      end
      #1;
      n_checks++;
      if (grants !== 2) $display("FAIL cap_grant_count: got %0d want 2", grants); else n_pass++;
      n_checks++;
      if (req_at_cap[0] !== 1'b1) $display("FAIL cap_flag: got %b want 1", req_at_cap[0]); else n_pass++;
      n_checks++;
      if (rob_alloc_ready !== 1'b0) $display("FAIL cap_alloc_ready: got %b want 0", rob_alloc_ready); else n_pass++;
   endtask

   task automatic test_completion_routing();
      do_reset();
      rob_alloc_valid    = 1'b1;
      req_alloc_ready    = 2'b01;
      rob_alloc_entry_id = 2'd0;
      #1;
      n_checks++;
      if (req_alloc_valid !== 2'b01) $display("FAIL route_alloc0: got %b want 01", req_alloc_valid); else n_pass++;
      tick();
      req_alloc_ready    = 2'b10;
      rob_alloc_entry_id = 2'd1;
      #1;
      n_checks++;
      if (req_alloc_valid !== 2'b10) $display("FAIL route_alloc1: got %b want 10", req_alloc_valid); else n_pass++;
      tick();
      set_idle();
      req_complete_ready    = 2'b11;
      rob_complete_valid    = 1'b1;
      rob_complete_entry_id = 2'd0;
      #1;
      n_checks++;
      if (req_complete_valid !== 2'b01) $display("FAIL route_cpl0: got %b want 01", req_complete_valid); else n_pass++;
      n_checks++;
      if (rob_complete_ready !== 1'b1) $display("FAIL route_cpl0_ready: got %b want 1", rob_complete_ready); else n_pass++;
      tick();
      rob_complete_entry_id = 2'd1;
      #1;
      n_checks++;
      if (req_complete_valid !== 2'b10) $display("FAIL route_cpl1: got %b want 10", req_complete_valid); else n_pass++;
      tick();
      set_idle();
   endtask

   task automatic test_complete_stall();
      do_reset();
      rob_alloc_valid = 1'b1;
      req_alloc_ready = 2'b01;
      rob_alloc_entry_id = 2'd0;
      tick();
      rob_alloc_entry_id = 2'd1;
      tick();
      set_idle();
      rob_complete_valid    = 1'b1;
      rob_complete_entry_id = 2'd0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++;
         if (rob_complete_ready !== 1'b0) $display("FAIL stall_ready[%0d]: got %b want 0", k, rob_complete_ready); else n_pass++;
         n_checks++;
         if (req_complete_valid !== 2'b01) $display("FAIL stall_valid[%0d]: got %b want 01", k, req_complete_valid); else n_pass++;
         n_checks++;
         if (req_at_cap[0] !== 1'b1) $display("FAIL stall_count_held[%0d]: got %b want 1", k, req_at_cap[0]); else n_pass++;
         tick();
      end
      req_complete_ready = 2'b01;
      #1;
      n_checks++;
      if (rob_complete_ready !== 1'b1) $display("FAIL stall_release: got %b want 1", rob_complete_ready); else n_pass++;
      tick();
      rob_complete_valid = 1'b0;
      #1;
      n_checks++;
      if (req_at_cap[0] !== 1'b0) $display("FAIL stall_count_dec: got %b want 0", req_at_cap[0]); else n_pass++;
   endtask

   // Continues from test_complete_stall: req0 still owns entry 1.
   task automatic test_cap_alloc_complete();
      req_alloc_ready    = 2'b01;
      rob_alloc_valid    = 1'b1;
      rob_alloc_entry_id = 2'd0;
      tick();
      rob_alloc_entry_id    = 2'd2;
      rob_complete_valid    = 1'b1;
      rob_complete_entry_id = 2'd1;
      req_complete_ready    = 2'b01;
      #1;
      n_checks++;
      if (req_alloc_valid !== 2'b00) $display("FAIL capcpl_grant: got %b want 00", req_alloc_valid); else n_pass++;
      n_checks++;
      if (rob_alloc_ready !== 1'b0) $display("FAIL capcpl_alloc_ready: got %b want 0", rob_alloc_ready); else n_pass++;
      n_checks++;
      if (req_at_cap[0] !== 1'b1) $display("FAIL capcpl_at_cap: got %b want 1", req_at_cap[0]); else n_pass++;
      n_checks++;
      if (rob_complete_ready !== 1'b1) $display("FAIL capcpl_cpl_ready: got %b want 1", rob_complete_ready); else n_pass++;
      tick();
      rob_complete_valid = 1'b0;
      #1;
      n_checks++;
      if (req_at_cap[0] !== 1'b0) $display("FAIL capcpl_after: got %b want 0", req_at_cap[0]); else n_pass++;
      n_checks++;
      if (req_alloc_valid !== 2'b01) $display("FAIL capcpl_regrant: got %b want 01", req_alloc_valid); else n_pass++;
      tick();
      #1;
      n_checks++;
      if (req_at_cap[0] !== 1'b1) $display("FAIL capcpl_recap: got %b want 1", req_at_cap[0]); else n_pass++;
      set_idle();
   endtask

   task automatic test_same_id();
      do_reset();
      req_alloc_ready    = 2'b01;
      rob_alloc_valid    = 1'b1;
      rob_alloc_entry_id = 2'd0;
      tick();
      req_alloc_ready       = 2'b10;
      rob_complete_valid    = 1'b1;
      rob_complete_entry_id = 2'd0;
      req_complete_ready    = 2'b11;
      #1;
      n_checks++;
      if (req_complete_valid !== 2'b01) $display("FAIL sameid_old_owner: got %b want 01", req_complete_valid); else n_pass++;
      n_checks++;
      if (req_alloc_valid !== 2'b10) $display("FAIL sameid_grant: got %b want 10", req_alloc_valid); else n_pass++;
      tick();
      rob_alloc_valid = 1'b0;
      req_alloc_ready = 2'b00;
      #1;
      n_checks++;
      if (req_complete_valid !== 2'b10) $display("FAIL sameid_new_owner: got %b want 10", req_complete_valid); else n_pass++;
      tick();
      set_idle();
      #1;
      n_checks++;
      if (req_at_cap !== 2'b00) $display("FAIL sameid_counts: got %b want 00", req_at_cap); else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         int free_ids [$];
         int cid;
         free_ids.delete();
         for (int e = 0; e < ENT; e++) if (!m_inuse[e]) free_ids.push_back(e);
         req_alloc_ready    = N'($urandom_range(0, 3));
         req_complete_ready = N'($urandom_range(0, 3));
         rob_complete_valid = (m_order.size() > 0) && ($urandom_range(0, 2) != 0);
         cid = (m_order.size() > 0) ? m_order[0] : 0;
         rob_complete_entry_id = IDW'(cid);
         rob_alloc_valid    = 1'b0;
         rob_alloc_entry_id = IDW'($urandom_range(0, ENT - 1));
         if (free_ids.size() > 0 && $urandom_range(0, 3) != 0) begin
            rob_alloc_valid    = 1'b1;
            rob_alloc_entry_id = IDW'(free_ids[$urandom_range(0, free_ids.size() - 1)]);
         end
         if (rob_complete_valid && req_complete_ready[m_owner[cid]] && $urandom_range(0, 3) == 0) begin
            rob_alloc_valid    = 1'b1;
            rob_alloc_entry_id = IDW'(cid);
         end
         #1;
         model_eval();
         n_checks++;
         if (req_alloc_valid !== e_alloc_valid) $display("FAIL rand_grant[%0d]: got %b want %b", cyc, req_alloc_valid, e_alloc_valid); else n_pass++;
         n_checks++;
         if (rob_alloc_ready !== e_rob_alloc_ready) $display("FAIL rand_alloc_ready[%0d]: got %b want %b", cyc, rob_alloc_ready, e_rob_alloc_ready); else n_pass++;
         n_checks++;
         if (req_at_cap !== e_at_cap) $display("FAIL rand_at_cap[%0d]: got %b want %b", cyc, req_at_cap, e_at_cap); else n_pass++;
         n_checks++;
         if (req_alloc_entry_id !== rob_alloc_entry_id) $display("FAIL rand_entry_id[%0d]: got %0d want %0d", cyc, req_alloc_entry_id, rob_alloc_entry_id); else n_pass++;
         n_checks++;
         if (req_complete_valid !== e_cpl_valid) $display("FAIL rand_cpl_valid[%0d]: got %b want %b", cyc, req_complete_valid, e_cpl_valid); else n_pass++;
         if (rob_complete_valid) begin
            n_checks++;
            if (rob_complete_ready !== e_rob_cpl_ready) $display("FAIL rand_cpl_ready[%0d]: got %b want %b", cyc, rob_complete_ready, e_rob_cpl_ready); else n_pass++;
         end
         tick();
      end
      set_idle();
   endtask

   task automatic test_mid_reset();
      do_reset();
      rob_alloc_valid    = 1'b1;
      req_alloc_ready    = 2'b11;
      rob_alloc_entry_id = 2'd0;
      tick();
      rob_alloc_entry_id = 2'd1;
      tick();
      req_alloc_ready    = 2'b01;
      rob_alloc_entry_id = 2'd2;
      tick();
      rob_alloc_valid = 1'b0;
      #1;
      n_checks++;
      if (req_at_cap !== 2'b01) $display("FAIL midrst_before: got %b want 01", req_at_cap); else n_pass++;
      req_alloc_ready       = 2'b11;
      rob_alloc_valid       = 1'b1;
      rob_alloc_entry_id    = 2'd3;
      rob_complete_valid    = 1'b1;
      rob_complete_entry_id = 2'd0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (req_at_cap !== 2'b00) $display("FAIL midrst_at_cap: got %b want 00", req_at_cap); else n_pass++;
      n_checks++;
      if (req_alloc_valid !== 2'b01) $display("FAIL midrst_ptr: got %b want 01", req_alloc_valid); else n_pass++;
      set_idle();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      req_alloc_ready    = 2'b11;
      rob_alloc_valid    = 1'b1;
      rob_alloc_entry_id = 2'd3;
      #1;
      n_checks++;
      if (req_alloc_valid !== 2'b01) $display("FAIL midrst_first_grant: got %b want 01", req_alloc_valid); else n_pass++;
      tick();
      set_idle();
      rob_complete_valid    = 1'b1;
      rob_complete_entry_id = 2'd3;
      req_complete_ready    = 2'b11;
      #1;
      n_checks++;
      if (req_complete_valid !== 2'b01) $display("FAIL midrst_cpl: got %b want 01", req_complete_valid); else n_pass++;
      tick();
      set_idle();
      tick();
   endtask

   initial begin
      for (int e = 0; e < ENT; e++) m_owner[e] = 0;
      set_idle();
      rst_n = 1'b1;
      #1;
      test_reset();
      test_round_robin();
      test_alloc_cap();
      test_completion_routing();
      test_complete_stall();
      test_cap_alloc_complete();
      test_same_id();
      test_random();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule
